// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_pkg
// Brief    : Shared types and constants for the RV32M multi-cycle divider.
// Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

   typedef enum logic [1:0] {
      OP_DIV  = 2'b00,
      OP_DIVU = 2'b01,
      OP_REM  = 2'b10,
      OP_REMU = 2'b11
   } div_op_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_CALC  = 2'b01,
      S_FIXUP = 2'b10,
      S_DONE  = 2'b11
   } div_state_t;

   localparam int DIV_ITERS = 32;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
// Module   : div_step
// Brief    : One combinational restoring-division step (shift, trial subtract).
// Revision : 1.0 - initial release
// ============================================================================
module div_step #(
   parameter int W = 32
) (
   input  logic [W:0]   i_rem,
   input  logic [W-1:0] i_div,
   input  logic         i_bit,
   output logic [W:0]   o_rem,
   output logic         o_q
);

   logic [W+1:0] w_shifted;
   logic [W+1:0] w_diff;

   // One guard bit above the shifted remainder keeps the borrow visible.
   assign w_shifted = {i_rem, i_bit};
   assign w_diff    = w_shifted - {2'b00, i_div};
   assign o_q       = ~w_diff[W+1];
   assign o_rem     = o_q ? w_diff[W:0] : w_shifted[W:0];

endmodule
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Brief    : Multi-cycle restoring divider for DIV/DIVU/REM/REMU.
//            Define DIV_FAST_EXC_EN to skip iteration for b==0 / signed overflow.
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [4:0]      rd_in,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);
   import div_pkg::*;

   localparam logic [4:0] LAST_CNT = 5'(DIV_ITERS - 1);

   div_state_t      r_state, w_state_nxt;
   logic [4:0]      r_cnt;
   logic [XLEN:0]   r_rem;
   logic [XLEN-1:0] r_dvd, r_div, r_a_orig, r_result;
   div_op_t         r_op;
   logic            r_sa, r_sb, r_bz, r_ovf;
   logic [4:0]      r_rd, r_rd_out;

   logic            w_signed_in, w_sa_in, w_sb_in, w_bz_in, w_ovf_in, w_accept;
   logic [XLEN-1:0] w_abs_a, w_abs_b;
   logic [XLEN:0]   w_rem_nxt;
   logic            w_q;
   logic [XLEN-1:0] w_quo, w_rmd, w_fix;
   logic            w_is_rem;

   assign w_signed_in = ~op[0];
   assign w_sa_in     = w_signed_in & a[XLEN-1];
   assign w_sb_in     = w_signed_in & b[XLEN-1];
   assign w_bz_in     = (b == '0);
   assign w_ovf_in    = w_signed_in && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
   assign w_abs_a     = w_sa_in ? (~a + 1'b1) : a;
   assign w_abs_b     = w_sb_in ? (~b + 1'b1) : b;
   assign w_accept    = (r_state == S_IDLE) && start;

   div_step #(.W(XLEN)) u_step (
      .i_rem (r_rem),
      .i_div (r_div),
      .i_bit (r_dvd[XLEN-1]),
      .o_rem (w_rem_nxt),
      .o_q   (w_q)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
`ifdef DIV_FAST_EXC_EN
               w_state_nxt = (w_bz_in || w_ovf_in) ? S_FIXUP : S_CALC;
`else
               w_state_nxt = S_CALC;
`endif
            end
         end
         S_CALC:  if (r_cnt == LAST_CNT) w_state_nxt = S_FIXUP;
         S_FIXUP: w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Sign correction plus the architectural special cases, which always win.
   always_comb begin
      w_is_rem = (r_op == OP_REM) || (r_op == OP_REMU);
      w_quo    = (r_sa ^ r_sb) ? (~r_dvd + 1'b1) : r_dvd;
      w_rmd    = r_sa ? (~r_rem[XLEN-1:0] + 1'b1) : r_rem[XLEN-1:0];
      if (r_bz)
         w_fix = w_is_rem ? r_a_orig : '1;
      else if (r_ovf)
         w_fix = w_is_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      else
         w_fix = w_is_rem ? w_rmd : w_quo;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= '0;
         r_div    <= '0;
         r_a_orig <= '0;
         r_op     <= OP_DIV;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_bz     <= 1'b0;
         r_ovf    <= 1'b0;
         r_rd     <= '0;
         r_result <= '0;
         r_rd_out <= '0;
      end else if (w_accept) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_dvd    <= w_abs_a;
         r_div    <= w_abs_b;
         r_a_orig <= a;
         r_op     <= div_op_t'(op);
         r_sa     <= w_sa_in;
         r_sb     <= w_sb_in;
         r_bz     <= w_bz_in;
         r_ovf    <= w_ovf_in;
         r_rd     <= rd_in;
      end else if (r_state == S_CALC) begin
         // Dividend bits shift out the top while quotient bits fill the bottom.
         r_rem <= w_rem_nxt;
         r_dvd <= {r_dvd[XLEN-2:0], w_q};
         r_cnt <= r_cnt + 5'd1;
      end else if (r_state == S_FIXUP) begin
         r_result <= w_fix;
         r_rd_out <= r_rd;
      end
   end

   assign busy   = (r_state == S_CALC) || (r_state == S_FIXUP);
   assign done   = (r_state == S_DONE);
   assign result = r_result;
   assign rd_out = r_rd_out;

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Brief    : Self-checking bench for div_unit against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = '0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [4:0]  rd_in = '0;
   logic        busy, done;
   logic [31:0] result;
   logic [4:0]  rd_out;

   int n_checks = 0;
   int n_errors = 0;

   div_unit #(.XLEN(32)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .rd_in  (rd_in),
      .busy   (busy),
      .done   (done),
      .result (result),
      .rd_out (rd_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      int sx, sy;
      sx = x;
      sy = y;
      if (y == 32'd0) return o[1] ? x : 32'hFFFF_FFFF;
      if (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
      case (o)
         2'd0:    return sx / sy;
         2'd1:    return x / y;
         2'd2:    return sx % sy;
         default: return x % y;
      endcase
   endfunction

   function automatic int exp_lat(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
      logic exc;
      exc = (y == 32'd0) || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
`ifdef DIV_FAST_EXC_EN
      return exc ? 2 : 34;
`else
      return exc ? 34 : 34;
`endif
   endfunction

   // Accept on the next edge, scramble operands, then count cycles to done.
   task automatic do_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, output int lat);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; rd_in = r;
      @(posedge clk); #1;
      start = 1'b0; a = $urandom; b = $urandom; rd_in = 5'($urandom);
      check("busy_after_accept", 32'(busy), 32'd1);
      lat = 1;
      while (!done && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic run_check(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                            input logic [4:0] r);
      int lat;
      do_op(o, x, y, r, lat);
      check("result", result, ref_div(o, x, y));
      check("rd_out", 32'(rd_out), 32'(r));
      check("latency", 32'(lat), 32'(exp_lat(o, x, y)));
      check("busy_in_done", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [1:0]  ro;
      logic [31:0] ra, rb;
      int          sel, ndone;
      logic [31:0] got_res;
      logic [4:0]  got_rd;

      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_result", result, 32'd0);
      check("reset_rd_out", 32'(rd_out), 32'd0);
      @(negedge clk) rst = 1'b0;

      run_check(2'd1, 32'd100, 32'd7, 5'd3);
      run_check(2'd3, 32'd100, 32'd7, 5'd4);
      run_check(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5);
      run_check(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6);
      run_check(2'd1, 32'd5, 32'd0, 5'd7);
      run_check(2'd2, 32'hFFFF_FFF0, 32'd0, 5'd8);
      run_check(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9);
      run_check(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);

      for (int i = 0; i < 40; i++) begin
         ro  = 2'($urandom_range(0, 3));
         sel = $urandom_range(0, 7);
         ra  = $urandom;
         rb  = $urandom;
         if (sel == 0) rb = 32'd0;
         else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
         else if (sel == 2) rb = $urandom_range(1, 15);
         else if (sel == 3) rb = -($urandom_range(1, 15));
         run_check(ro, ra, rb, 5'($urandom));
      end

      // A second start mid-operation must be dropped.
      @(negedge clk);
      start = 1'b1; op = 2'd1; a = 32'd100; b = 32'd7; rd_in = 5'd11;
      @(posedge clk); #1;
      start = 1'b0;
      ndone = 0; got_res = '0; got_rd = '0;
      for (int c = 1; c <= 45; c++) begin
         @(negedge clk);
         start = (c == 10);
         if (c == 10) begin op = 2'd0; a = 32'd1000; b = 32'd3; rd_in = 5'd22; end
         @(posedge clk); #1;
         if (done) begin ndone++; got_res = result; got_rd = rd_out; end
      end
      start = 1'b0;
      check("ignore_done_count", 32'(ndone), 32'd1);
      check("ignore_result", got_res, 32'd14);
      check("ignore_rd_out", 32'(got_rd), 32'd11);

      // Asynchronous reset partway through an operation.
      @(negedge clk);
      start = 1'b1; op = 2'd1; a = 32'd1000; b = 32'd3; rd_in = 5'd12;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_result", result, 32'd0);
      @(posedge clk);
      @(negedge clk) rst = 1'b0;
      ndone = 0;
      for (int c = 0; c < 40; c++) begin
         @(posedge clk); #1;
         if (done) ndone++;
      end
      check("midrst_no_done", 32'(ndone), 32'd0);
      run_check(2'd1, 32'd1000, 32'd3, 5'd13);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/div_unit.md
# div_unit

Multi-cycle integer divider for the RV32M DIV/DIVU/REM/REMU instructions. It sits directly downstream of the register file: it takes the two read-port values (rs1 and rs2 operands) plus the destination register index, and iterates a restoring division. It returns the result and destination index to the write-back path, which drives the register-file write port. The core stalls on `busy`.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `op`  input  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- `a`  input  XLEN  dividend (rs1 read data).
- `b`  input  XLEN  divisor (rs2 read data).
- `rd_in`  input  5  destination register index.
- `busy`  output  1  high while an operation is in flight (CALC, FIXUP).
- `done`  output  1  one-cycle pulse; `result` and `rd_out` are valid in that cycle.
- `result`  output  XLEN  quotient or remainder; held until the next accepted start.
- `rd_out`  output  5  latched `rd_in`; held like `result`.

## Operation
- States:
  - IDLE: `start` → CALC, or → FIXUP on the fast path.
  - CALC: 32 iterations, then → FIXUP.
  - FIXUP: one cycle → DONE.
  - DONE: one cycle → IDLE.
- On accept, the unit latches `op`, `rd_in` and the sign flags of `a` and `b` (signed ops only). It loads |a| and |b| for signed ops, and raw values for unsigned ops.
- CALC performs one restoring step per cycle:
  - Shift the 33-bit partial remainder left by one and bring in the next dividend MSB.
  - Trial-subtract the divisor.
  - If the difference is non-negative, keep it and shift a 1 into the quotient; otherwise shift a 0.
- A 5-bit counter runs 0..31 and leaves CALC when it reaches 31.
- FIXUP rules:
  - Signed quotient is negated if sign(a) XOR sign(b).
  - Signed remainder is negated if sign(a).
  - b == 0: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the original `a`.
  - DIV with a = 0x80000000, b = 0xFFFFFFFF gives 0x80000000; the matching REM gives 0.
  - These special cases override the iterative result regardless of configuration.
- `start` outside IDLE is ignored, with no queuing.
- `result` and `rd_out` are registered and update only on the FIXUP→DONE edge.
- Reset mid-operation aborts the operation with no `done`.
- Reset values: state IDLE, `busy` 0, `done` 0, `result` 0, `rd_out` 0, counter 0.

## Timing
- Edge E0 samples `start`=1 in IDLE.
- E32 enters FIXUP; E33 enters DONE, so `done` is high in the cycle after E33.
- Latency is 34 cycles from the accept edge to the `done` cycle.
- E34 returns to IDLE, so the next start is accepted at E35 at the earliest.
- `busy` rises after E0 and falls after E33. It is low in DONE and IDLE.
- Operands need to be valid only in the accept cycle.

## Configuration
- `DIV_FAST_EXC_EN` defined: in IDLE, b == 0 or signed overflow goes straight to FIXUP. Latency drops to 2 cycles (`done` after E1).
- Undefined: every operation takes the full 34 cycles.
- Results are identical with or without the macro.

## Structure
- Package `div_pkg`:
  - `div_op_t` enum for DIV/DIVU/REM/REMU.
  - `div_state_t` enum for IDLE/CALC/FIXUP/DONE.
  - Localparam `DIV_ITERS = 32`.
- Sub-module `div_step` is combinational: it takes the 33-bit remainder, divisor and next dividend bit, and returns the new remainder and quotient bit. It is instantiated once.

## Test plan
- DIVU a=100, b=7 → `result`=14, `rd_out`=`rd_in`, `done` exactly 34 cycles after accept; REMU on the same operands → 2.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD (−3); REM → 0xFFFFFFFF (−1).
- b=0:
  - DIVU a=5 → 0xFFFFFFFF.
  - REM a=0xFFFFFFF0 → 0xFFFFFFF0.
  - Latency is 2 cycles with `DIV_FAST_EXC_EN` and 34 without.
- DIV a=0x80000000, b=0xFFFFFFFF → 0x80000000; REM → 0.
- `start` pulsed at cycle 10 of a running op with different operands → ignored; the first result is unchanged and only one `done` pulse occurs.
- `rst` asserted at cycle 15 → `busy`=0, `done`=0, `result`=0 immediately. A new start after release completes normally.
